// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of a
// byte-addressed RAM.
//   req_*      : request handshake (req_valid/req_ready) carrying we, funct3,
//                byte address and right-aligned store data.
//   resp_*     : response handshake (resp_valid/resp_ready) carrying the
//                extended load data and an error flag.
//   ram_*      : RAM port. ram_w_mode selects the write size (0 = no write),
//                ram_oe enables a read, and ram_data_out is combinational
//                read data for bytes addr+3..addr.
// Flow is IDLE -> ACCESS -> RESP -> IDLE. Illegal or misaligned requests
// skip ACCESS, so the RAM is never touched for them.
module load_store_unit #(
  parameter int W  = 32,
  parameter int L  = 64,
  parameter int AW = $clog2(L*(W/8))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W-1:0]  resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] ram_addr,
  output logic [W-1:0]  ram_data_in,
  output logic [1:0]    ram_w_mode,
  output logic          ram_oe,
  input  logic [W-1:0]  ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  wdata_q;
  logic [W-1:0]  rdata_q;
  logic          err_q;

  logic          legal, aligned, accept;
  logic [W-1:0]  load_ext;

  // Request decode on the live inputs; only meaningful in the accept cycle.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;   // unsigned forms are load-only
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (req_funct3[1:0])
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign accept = req_valid && (state_q == IDLE);

  // Load extension of the live RAM data, captured at the end of ACCESS.
  always_comb begin
    load_ext = ram_data_out;
    case (f3_q)
      3'b000:  load_ext = {{(W-8){ram_data_out[7]}},   ram_data_out[7:0]};
      3'b100:  load_ext = {{(W-8){1'b0}},              ram_data_out[7:0]};
      3'b001:  load_ext = {{(W-16){ram_data_out[15]}}, ram_data_out[15:0]};
      3'b101:  load_ext = {{(W-16){1'b0}},             ram_data_out[15:0]};
      default: load_ext = ram_data_out;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (legal && aligned) ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request/response holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;                 // stores and errors respond with zero
      err_q   <= ~(legal && aligned);
    end else if (state_q == ACCESS && !we_q) begin
      rdata_q <= load_ext;
    end
  end

  // Outputs. Everything is zero outside its owning state, so the RAM port
  // is quiet except in ACCESS and an async reset kills a pending write.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    ram_w_mode  = 2'd0;
    ram_oe      = 1'b0;
    case (state_q)
      IDLE:   req_ready = rst_n;
      ACCESS: begin
        ram_addr = addr_q;
        if (we_q) begin
          ram_w_mode  = f3_q[1:0] + 2'd1;  // b/h/w -> 1/2/3
          ram_data_in = wdata_q;
        end else begin
          ram_oe = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit. A byte-array RAM sits on
// the DUT's RAM port; an independent byte-array reference memory and the
// access rules predict every response.
module tb_load_store_unit;
  localparam int W = 32, L = 64, AW = 8;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [W-1:0]  resp_rdata;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_data_in, ram_data_out;
  logic [1:0]    ram_w_mode;
  logic          ram_oe;

  int nvec = 0, nerr = 0;
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  load_store_unit #(.W(W), .L(L), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_w_mode(ram_w_mode),
    .ram_oe(ram_oe), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed RAM, not affected by reset.
  always @(posedge clk) begin
    case (ram_w_mode)
      2'd1: mem[ram_addr] <= ram_data_in[7:0];
      2'd2: begin
        mem[ram_addr]        <= ram_data_in[7:0];
        mem[ram_addr + 8'd1] <= ram_data_in[15:8];
      end
      2'd3: begin
        mem[ram_addr]        <= ram_data_in[7:0];
        mem[ram_addr + 8'd1] <= ram_data_in[15:8];
        mem[ram_addr + 8'd2] <= ram_data_in[23:16];
        mem[ram_addr + 8'd3] <= ram_data_in[31:24];
      end
      default: ;
    endcase
  end
  assign ram_data_out = {mem[ram_addr + 8'd3], mem[ram_addr + 8'd2],
                         mem[ram_addr + 8'd1], mem[ram_addr]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from a negedge to the negedge after the response is taken.
  // hold = number of RESP cycles with resp_ready low.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [7:0] a,
                     input logic [31:0] wd, input int hold, output logic [31:0] got);
    int size;
    bit ok;
    longint unsigned v;
    logic [31:0] exp_rd;
    size = 1 << f3[1:0];
    ok = (we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5)) && (a % size == 0);
    exp_rd = 32'h0;
    if (ok && !we) begin
      v = 0;
      for (int i = 0; i < size; i++) v |= longint'(ref_mem[8'(a + i)]) << (8 * i);
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
      exp_rd = v[31:0];
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ok && we)
      for (int i = 0; i < size; i++) ref_mem[8'(a + i)] = wd[8*i +: 8];
    if (ok) begin
      @(negedge clk);
      chk("acc_resp_valid", 32'(resp_valid), 32'd0);
      chk("acc_ram_addr",   32'(ram_addr), 32'(a));
      chk("acc_w_mode",     32'(ram_w_mode), we ? 32'(f3[1:0]) + 32'd1 : 32'd0);
      chk("acc_oe",         32'(ram_oe), 32'(!we));
      if (we) chk("acc_data_in", ram_data_in, wd);
    end
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err",   32'(resp_err), 32'(!ok));
    chk("resp_w_mode", 32'(ram_w_mode), 32'd0);
    got = resp_rdata;
    if (hold > 0) begin
      // A request offered outside IDLE must be ignored entirely.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 8'h40;
      req_wdata = $urandom;
      for (int h = 1; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_rdata", resp_rdata, exp_rd);
        chk("hold_err",   32'(resp_err), 32'(!ok));
        chk("hold_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_req_ready",  32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 8'h10; req_wdata = 32'hFFFFFFFF; resp_ready = 1'b1;
    #12;
    chk("rst_req_ready",  32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_addr",   32'(ram_addr), 32'd0);
    chk("rst_ram_din",    ram_data_in, 32'd0);
    chk("rst_w_mode",     32'(ram_w_mode), 32'd0);
    chk("rst_oe",         32'(ram_oe), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("rel_req_ready", 32'(req_ready), 32'd1);

    // Word store/load, then sub-word loads.
    txn(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 0, r);
    txn(1'b0, 3'b010, 8'h10, 32'h0, 0, r); chk("lw_10",  r, 32'hDEADBEEF);
    txn(1'b0, 3'b000, 8'h13, 32'h0, 0, r); chk("lb_13",  r, 32'hFFFFFFDE);
    txn(1'b0, 3'b100, 8'h13, 32'h0, 0, r); chk("lbu_13", r, 32'h000000DE);
    txn(1'b0, 3'b001, 8'h12, 32'h0, 0, r); chk("lh_12",  r, 32'hFFFFDEAD);
    txn(1'b0, 3'b101, 8'h10, 32'h0, 0, r); chk("lhu_10", r, 32'h0000BEEF);
    txn(1'b1, 3'b000, 8'h11, 32'h12345677, 0, r);
    txn(1'b0, 3'b010, 8'h10, 32'h0, 0, r); chk("lw_10_sb", r, 32'hDEAD77EF);

    // Rejected requests.
    txn(1'b0, 3'b010, 8'h02, 32'h0, 0, r);
    txn(1'b1, 3'b001, 8'h01, 32'h5555AAAA, 0, r);
    txn(1'b0, 3'b011, 8'h00, 32'h0, 0, r);
    txn(1'b1, 3'b100, 8'h00, 32'h0, 0, r);

    // Back-pressure, then confirm the ignored store never landed.
    txn(1'b0, 3'b010, 8'h10, 32'h0, 5, r);
    txn(1'b0, 3'b010, 8'h40, 32'h0, 0, r); chk("lw_40_ignored", r, 32'h0);

    // Reset in the middle of a store's ACCESS cycle aborts the write.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 8'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_w_mode",     32'(ram_w_mode), 32'd0);
    chk("abort_ram_addr",   32'(ram_addr), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_req_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 3'b010, 8'h20, 32'h0, 0, r); chk("lw_20_after_abort", r, 32'h0);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 60; n++)
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          8'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), r);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
